// File: rtl/scratch_pad_arbiter_pkg.sv
// rtl/scratch_pad_arbiter_pkg.sv - shared types and constants for the scratch pad arbiter
package pkg_sp_arb;

    localparam int unsigned BURST_W_DEFAULT = 4;

    typedef enum logic {
        IDLE,
        ENG_BURST
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_ENG
    } sp_owner_e;

endpackage

// File: rtl/scratch_pad_arbiter_rr_pick.sv
// rtl/scratch_pad_arbiter_rr_pick.sv - 2-way round-robin picker, grant one-hot {eng, core}
module sp_rr_pick (
    input  logic       req_core_i,
    input  logic       req_eng_i,
    input  logic       last_grant_eng_i,
    output logic [1:0] gnt_o
);

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        gnt_o = 2'b00;
        if (req_core_i && req_eng_i) begin
            gnt_o = last_grant_eng_i ? 2'b01 : 2'b10;
        end else if (req_core_i) begin
            gnt_o = 2'b01;
        end else if (req_eng_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/scratch_pad_arbiter.sv
// rtl/scratch_pad_arbiter.sv - shares one scratch pad port between the core and the MLP engine
module scratch_pad_arbiter
    import pkg_sp_arb::*;
#(
    parameter int unsigned DWidth = 32,
    parameter int unsigned BurstW = BURST_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic [DWidth-1:0] core_addr_i,
    input  logic              core_write_i,
    input  logic [DWidth-1:0] core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_ready_o,
    output logic [DWidth-1:0] core_rdata_o,
    input  logic              eng_req_i,
    input  logic [DWidth-1:0] eng_addr_i,
    input  logic              eng_write_i,
    input  logic [DWidth-1:0] eng_wdata_i,
    input  logic [BurstW-1:0] eng_burst_i,
    output logic              eng_gnt_o,
    output logic              eng_ready_o,
    output logic [DWidth-1:0] eng_rdata_o,
    output logic              sp_request_o,
    output logic [DWidth-1:0] sp_addr_o,
    output logic              sp_write_o,
    output logic [DWidth-1:0] sp_write_data_o,
    input  logic              sp_ready_i,
    input  logic [DWidth-1:0] sp_read_data_i
);

    arb_state_e        state_q, state_d;
    logic [BurstW-1:0] beats_left_q, beats_left_d;
    logic              last_eng_q, last_eng_d;
    sp_owner_e         resp_owner_q, resp_owner_d;
    logic [1:0]        rr_gnt;
    logic              core_gnt, eng_gnt;

    sp_rr_pick u_rr_pick (
        .req_core_i       (core_req_i),
        .req_eng_i        (eng_req_i),
        .last_grant_eng_i (last_eng_q),
        .gnt_o            (rr_gnt)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            last_eng_q   <= 1'b1;
            resp_owner_q <= OWN_NONE;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            last_eng_q   <= last_eng_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    // Grants are gated by reset so nothing reaches the scratch pad while rst_ni is low.
    always_comb begin
        core_gnt = 1'b0;
        eng_gnt  = 1'b0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    core_gnt = rr_gnt[0];
                    eng_gnt  = rr_gnt[1];
                end
                ENG_BURST: eng_gnt = eng_req_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        case (state_q)
            IDLE: begin
                if (eng_gnt && (eng_burst_i != '0)) begin
                    state_d      = ENG_BURST;
                    beats_left_d = eng_burst_i;
                end
            end
            ENG_BURST: begin
                if (eng_req_i) begin
                    beats_left_d = beats_left_q - BurstW'(1);
                    if (beats_left_q == BurstW'(1)) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d      = IDLE;
                    beats_left_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        last_eng_d   = core_gnt ? 1'b0 : (eng_gnt ? 1'b1 : last_eng_q);
        resp_owner_d = core_gnt ? OWN_CORE : (eng_gnt ? OWN_ENG : OWN_NONE);
    end

    always_comb begin
        core_gnt_o      = core_gnt;
        eng_gnt_o       = eng_gnt;
        sp_request_o    = core_gnt | eng_gnt;
        sp_addr_o       = '0;
        sp_write_o      = 1'b0;
        sp_write_data_o = '0;
        if (core_gnt) begin
            sp_addr_o       = core_addr_i;
            sp_write_o      = core_write_i;
            sp_write_data_o = core_wdata_i;
        end else if (eng_gnt) begin
            sp_addr_o       = eng_addr_i;
            sp_write_o      = eng_write_i;
            sp_write_data_o = eng_wdata_i;
        end
        // The response belongs to whoever owned the issuing cycle.
        core_ready_o = rst_ni & sp_ready_i & (resp_owner_q == OWN_CORE);
        eng_ready_o  = rst_ni & sp_ready_i & (resp_owner_q == OWN_ENG);
        core_rdata_o = core_ready_o ? sp_read_data_i : '0;
        eng_rdata_o  = eng_ready_o ? sp_read_data_i : '0;
    end

endmodule

// File: tb/tb_scratch_pad_arbiter.sv
// tb/tb_scratch_pad_arbiter.sv - directed self-checking bench for scratch_pad_arbiter
module tb_scratch_pad_arbiter;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_write, eng_req, eng_write;
    logic [31:0] core_addr, core_wdata, eng_addr, eng_wdata;
    logic [3:0]  eng_burst;
    logic        core_gnt, core_ready, eng_gnt, eng_ready;
    logic [31:0] core_rdata, eng_rdata;
    logic        sp_request, sp_write, sp_ready;
    logic [31:0] sp_addr, sp_wdata, sp_rdata;

    logic [31:0] mem [256];
    logic [255:0] mem_vld;
    int total = 0;
    int bad = 0;
    int rdy_cnt;

    scratch_pad_arbiter #(.DWidth(32), .BurstW(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .core_req_i      (core_req),
        .core_addr_i     (core_addr),
        .core_write_i    (core_write),
        .core_wdata_i    (core_wdata),
        .core_gnt_o      (core_gnt),
        .core_ready_o    (core_ready),
        .core_rdata_o    (core_rdata),
        .eng_req_i       (eng_req),
        .eng_addr_i      (eng_addr),
        .eng_write_i     (eng_write),
        .eng_wdata_i     (eng_wdata),
        .eng_burst_i     (eng_burst),
        .eng_gnt_o       (eng_gnt),
        .eng_ready_o     (eng_ready),
        .eng_rdata_o     (eng_rdata),
        .sp_request_o    (sp_request),
        .sp_addr_o       (sp_addr),
        .sp_write_o      (sp_write),
        .sp_write_data_o (sp_wdata),
        .sp_ready_i      (sp_ready),
        .sp_read_data_i  (sp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratch pad model: unwritten words read back as C0DE_00xx, idle cycles return all ones.
    always @(posedge clk) begin
        sp_ready <= sp_request;
        if (!rst_n) begin
            mem_vld <= '0;
        end
        if (sp_request && sp_write) begin
            mem[sp_addr[9:2]]     <= sp_wdata;
            mem_vld[sp_addr[9:2]] <= 1'b1;
            sp_rdata              <= 32'h5A5A_5A5A;
        end else if (sp_request) begin
            sp_rdata <= mem_vld[sp_addr[9:2]] ? mem[sp_addr[9:2]] : (32'hC0DE_0000 | {24'h0, sp_addr[9:2]});
        end else begin
            sp_rdata <= 32'hFFFF_FFFF;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; core_req = 0; core_write = 0; core_addr = 0; core_wdata = 0;
        eng_req = 0; eng_write = 0; eng_addr = 0; eng_wdata = 0; eng_burst = 0;
        step();
        step();
        core_req = 1; eng_req = 1; #1;
        check_eq("rst_core_gnt", 32'(core_gnt), 0);
        check_eq("rst_eng_gnt", 32'(eng_gnt), 0);
        check_eq("rst_sp_req", 32'(sp_request), 0);
        core_req = 0; eng_req = 0;
        step();
        rst_n = 1'b1;
        step();

        // core-only read
        core_req = 1; core_addr = 32'h0000_1004; core_write = 0; #1;
        check_eq("t1_core_gnt", 32'(core_gnt), 1);
        check_eq("t1_sp_req", 32'(sp_request), 1);
        check_eq("t1_sp_addr", sp_addr, 32'h0000_1004);
        step();
        core_req = 0; #1;
        check_eq("t1_core_ready", 32'(core_ready), 1);
        check_eq("t1_core_rdata", core_rdata, 32'hC0DE_0001);
        check_eq("t1_eng_ready", 32'(eng_ready), 0);
        step();
        check_eq("t1_idle_ready", 32'(core_ready), 0);
        check_eq("t1_idle_rdata", core_rdata, 0);

        // simultaneous single requests alternate starting with the core
        do_reset();
        for (int i = 0; i < 4; i++) begin
            core_req = 1; eng_req = 1; eng_burst = 0;
            core_addr = 32'h100 + 32'(i) * 4; eng_addr = 32'h200 + 32'(i) * 4; #1;
            check_eq($sformatf("t2_core_gnt%0d", i), 32'(core_gnt), 32'(i % 2 == 0));
            check_eq($sformatf("t2_eng_gnt%0d", i), 32'(eng_gnt), 32'(i % 2 == 1));
            if (i > 0) begin
                check_eq($sformatf("t2_core_rdy%0d", i), 32'(core_ready), 32'(i % 2 == 1));
                check_eq($sformatf("t2_eng_rdy%0d", i), 32'(eng_ready), 32'(i % 2 == 0));
            end
            step();
        end
        core_req = 0; eng_req = 0; #1;
        check_eq("t2_eng_rdy_last", 32'(eng_ready), 1);
        check_eq("t2_eng_rdata_last", eng_rdata, 32'hC0DE_0083);
        check_eq("t2_core_rdy_last", 32'(core_ready), 0);
        step();

        // burst of 4 beats holds the core off; later burst field changes are ignored
        core_req = 1; core_addr = 32'h40; #1;
        check_eq("t3_pre_core_gnt", 32'(core_gnt), 1);
        step();
        for (int i = 0; i < 4; i++) begin
            eng_req = 1;
            eng_burst = (i == 0) ? 4'd3 : 4'd7;
            eng_addr = 32'h300 + 32'(i) * 4; #1;
            check_eq($sformatf("t3_eng_gnt%0d", i), 32'(eng_gnt), 1);
            check_eq($sformatf("t3_core_gnt%0d", i), 32'(core_gnt), 0);
            step();
        end
        eng_req = 0; #1;
        check_eq("t3_core_gnt5", 32'(core_gnt), 1);
        check_eq("t3_eng_gnt5", 32'(eng_gnt), 0);
        step();
        core_req = 0;
        step();

        // burst abort after two beats
        rdy_cnt = 0;
        eng_req = 1; eng_burst = 4'd5; eng_addr = 32'h400; #1;
        check_eq("t4_eng_gnt_a", 32'(eng_gnt), 1);
        step();
        core_req = 1; core_addr = 32'h44; #1;
        check_eq("t4_eng_gnt_b", 32'(eng_gnt), 1);
        check_eq("t4_core_gnt_b", 32'(core_gnt), 0);
        rdy_cnt += 32'(eng_ready);
        step();
        eng_req = 0; #1;
        check_eq("t4_drop_eng_gnt", 32'(eng_gnt), 0);
        check_eq("t4_drop_core_gnt", 32'(core_gnt), 0);
        check_eq("t4_drop_sp_req", 32'(sp_request), 0);
        rdy_cnt += 32'(eng_ready);
        step();
        check_eq("t4_core_gnt_d", 32'(core_gnt), 1);
        rdy_cnt += 32'(eng_ready);
        step();
        core_req = 0; #1;
        check_eq("t4_core_ready_e", 32'(core_ready), 1);
        rdy_cnt += 32'(eng_ready);
        step();
        rdy_cnt += 32'(eng_ready);
        check_eq("t4_eng_ready_cnt", 32'(rdy_cnt), 2);

        // reset in the middle of a burst
        eng_req = 1; eng_burst = 4'd3; eng_addr = 32'h500;
        step();
        step();
        rst_n = 0; core_req = 1; #1;
        check_eq("t5_rst_eng_gnt", 32'(eng_gnt), 0);
        check_eq("t5_rst_core_gnt", 32'(core_gnt), 0);
        check_eq("t5_rst_sp_req", 32'(sp_request), 0);
        check_eq("t5_rst_eng_ready", 32'(eng_ready), 0);
        check_eq("t5_rst_eng_rdata", eng_rdata, 0);
        step();
        check_eq("t5_rst2_eng_gnt", 32'(eng_gnt), 0);
        check_eq("t5_rst2_sp_addr", sp_addr, 0);
        rst_n = 1; #1;
        check_eq("t5_rel_core_gnt", 32'(core_gnt), 1);
        check_eq("t5_rel_eng_gnt", 32'(eng_gnt), 0);
        check_eq("t5_rel_eng_ready", 32'(eng_ready), 0);
        step();
        core_req = 0; eng_req = 0;
        step();

        // core write followed by an engine read of the same word
        core_req = 1; core_write = 1; core_addr = 32'h0000_01FE; core_wdata = 32'h1234_5678; #1;
        check_eq("t6_core_gnt", 32'(core_gnt), 1);
        check_eq("t6_sp_write", 32'(sp_write), 1);
        check_eq("t6_sp_wdata", sp_wdata, 32'h1234_5678);
        step();
        core_req = 0; core_write = 0;
        eng_req = 1; eng_write = 0; eng_addr = 32'h0000_01FE; eng_burst = 0; #1;
        check_eq("t6_eng_gnt", 32'(eng_gnt), 1);
        check_eq("t6_core_wr_ready", 32'(core_ready), 1);
        step();
        eng_req = 0; #1;
        check_eq("t6_eng_ready", 32'(eng_ready), 1);
        check_eq("t6_eng_rdata", eng_rdata, 32'h1234_5678);
        check_eq("t6_core_ready", 32'(core_ready), 0);
        check_eq("t6_core_rdata", core_rdata, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
